register_file: RTL and testbench

Architectural register file with rename tags for the out-of-order core. It sits between the decoder and the reorder buffer. For each issuing instruction it supplies operand values or the ROB ids those operands depend on, records the new destination-to-ROB mapping, and retires the ROB head's result into the architectural state. Operand lookups forward from the ROB's ready results and from the same-cycle commit, so no operand waits a cycle it does not need to.

---
 rtl/register_file.sv | 124 ++++++++++++
 tb/tb_register_file.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// Architectural register file with rename tags: supplies operand values or pending ROB ids,
// records destination renames and retires committed results.
module register_file #(
    parameter int unsigned REG_COUNT = 32,
    parameter int unsigned REG_WIDTH = 5,
    parameter int unsigned ROB_WIDTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 flush,

    input  logic [REG_WIDTH-1:0] dec_rs1,
    input  logic [REG_WIDTH-1:0] dec_rs2,
    output logic [31:0]          dec_val_j,
    output logic [31:0]          dec_val_k,
    output logic                 dec_has_dep_j,
    output logic                 dec_has_dep_k,
    output logic [ROB_WIDTH-1:0] dec_dep_j,
    output logic [ROB_WIDTH-1:0] dec_dep_k,
    input  logic                 dec_rdy,
    input  logic [REG_WIDTH-1:0] dec_rd,
    input  logic [ROB_WIDTH-1:0] dec_rob_id,

    output logic [ROB_WIDTH-1:0] rob_id_j,
    output logic [ROB_WIDTH-1:0] rob_id_k,
    input  logic                 rob_ready_j,
    input  logic                 rob_ready_k,
    input  logic [31:0]          rob_data_j,
    input  logic [31:0]          rob_data_k,

    input  logic [REG_WIDTH-1:0] commit_reg_id,
    input  logic [31:0]          commit_data,
    input  logic [ROB_WIDTH-1:0] commit_rob_id
);

    logic [31:0]          val_q  [REG_COUNT];
    logic [31:0]          val_d  [REG_COUNT];
    logic                 busy_q [REG_COUNT];
    logic                 busy_d [REG_COUNT];
    logic [ROB_WIDTH-1:0] tag_q  [REG_COUNT];
    logic [ROB_WIDTH-1:0] tag_d  [REG_COUNT];

    assign rob_id_j = tag_q[dec_rs1];
    assign rob_id_k = tag_q[dec_rs2];

    // Operand j: architectural value, then same-cycle commit, then ROB result, else wait.
    always_comb begin
        dec_val_j     = '0;
        dec_has_dep_j = 1'b0;
        dec_dep_j     = '0;
        if (dec_rs1 != '0) begin
            if (!busy_q[dec_rs1]) begin
                dec_val_j = val_q[dec_rs1];
            end else if (commit_reg_id == dec_rs1 && commit_rob_id == tag_q[dec_rs1]) begin
                dec_val_j = commit_data;
            end else if (rob_ready_j) begin
                dec_val_j = rob_data_j;
            end else begin
                dec_has_dep_j = 1'b1;
                dec_dep_j     = tag_q[dec_rs1];
            end
        end
    end

    always_comb begin
        dec_val_k     = '0;
        dec_has_dep_k = 1'b0;
        dec_dep_k     = '0;
        if (dec_rs2 != '0) begin
            if (!busy_q[dec_rs2]) begin
                dec_val_k = val_q[dec_rs2];
            end else if (commit_reg_id == dec_rs2 && commit_rob_id == tag_q[dec_rs2]) begin
                dec_val_k = commit_data;
            end else if (rob_ready_k) begin
                dec_val_k = rob_data_k;
            end else begin
                dec_has_dep_k = 1'b1;
                dec_dep_k     = tag_q[dec_rs2];
            end
        end
    end

    always_comb begin
        val_d  = val_q;
        busy_d = busy_q;
        tag_d  = tag_q;
        if (rdy_in) begin
            if (flush) begin
                for (int unsigned r = 0; r < REG_COUNT; r++) begin
                    busy_d[r] = 1'b0;
                end
            end else begin
                if (commit_reg_id != '0) begin
                    val_d[commit_reg_id] = commit_data;
                    // A stale commit (register already renamed to a younger id) keeps busy.
                    if (busy_q[commit_reg_id] && tag_q[commit_reg_id] == commit_rob_id) begin
                        busy_d[commit_reg_id] = 1'b0;
                    end
                end
                // Applied after commit so a same-register rename owns busy and tag.
                if (dec_rdy && dec_rd != '0) begin
                    busy_d[dec_rd] = 1'b1;
                    tag_d[dec_rd]  = dec_rob_id;
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int unsigned r = 0; r < REG_COUNT; r++) begin
                val_q[r]  <= '0;
                busy_q[r] <= 1'b0;
                tag_q[r]  <= '0;
            end
        end else begin
            val_q  <= val_d;
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios followed by random traffic,
// compared against an architectural model of values, busy bits and rename tags.
module tb_register_file;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic [31:0] dec_val_j, dec_val_k;
    logic        dec_has_dep_j, dec_has_dep_k;
    logic [3:0]  dec_dep_j, dec_dep_k;
    logic        dec_rdy;
    logic [3:0]  dec_rob_id;
    logic [3:0]  rob_id_j, rob_id_k;
    logic        rob_ready_j, rob_ready_k;
    logic [31:0] rob_data_j, rob_data_k;
    logic [4:0]  commit_reg_id;
    logic [31:0] commit_data;
    logic [3:0]  commit_rob_id;

    int total = 0;
    int bad   = 0;

    // Architectural model; tags become unknown after a flush.
    logic [31:0] mval   [32];
    logic        mbusy  [32];
    logic [3:0]  mtag   [32];
    logic        mknown [32];

    always #5 clk_in = ~clk_in;

    register_file dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .flush        (flush),
        .dec_rs1      (dec_rs1),
        .dec_rs2      (dec_rs2),
        .dec_val_j    (dec_val_j),
        .dec_val_k    (dec_val_k),
        .dec_has_dep_j(dec_has_dep_j),
        .dec_has_dep_k(dec_has_dep_k),
        .dec_dep_j    (dec_dep_j),
        .dec_dep_k    (dec_dep_k),
        .dec_rdy      (dec_rdy),
        .dec_rd       (dec_rd),
        .dec_rob_id   (dec_rob_id),
        .rob_id_j     (rob_id_j),
        .rob_id_k     (rob_id_k),
        .rob_ready_j  (rob_ready_j),
        .rob_ready_k  (rob_ready_k),
        .rob_data_j   (rob_data_j),
        .rob_data_k   (rob_data_k),
        .commit_reg_id(commit_reg_id),
        .commit_data  (commit_data),
        .commit_rob_id(commit_rob_id)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            mval[r] = '0; mbusy[r] = 1'b0; mtag[r] = '0; mknown[r] = 1'b1;
        end
    endtask

    function automatic void expect_op(input logic [4:0] rs, input logic rr, input logic [31:0] rd_v,
                                      output logic [31:0] v, output logic dep,
                                      output logic [3:0] id);
        v = '0; dep = 1'b0; id = '0;
        if (rs != 5'd0) begin
            if (!mbusy[rs]) v = mval[rs];
            else if (commit_reg_id == rs && commit_rob_id == mtag[rs]) v = commit_data;
            else if (rr) v = rd_v;
            else begin dep = 1'b1; id = mtag[rs]; end
        end
    endfunction

    task automatic check_ops(input string tag);
        logic [31:0] v;
        logic        d;
        logic [3:0]  id;
        expect_op(dec_rs1, rob_ready_j, rob_data_j, v, d, id);
        chk({tag, ".val_j"}, dec_val_j, v);
        chk({tag, ".dep_j"}, 32'(dec_has_dep_j), 32'(d));
        if (d) chk({tag, ".tag_j"}, 32'(dec_dep_j), 32'(id));
        if (mknown[dec_rs1]) chk({tag, ".rob_id_j"}, 32'(rob_id_j), 32'(mtag[dec_rs1]));
        expect_op(dec_rs2, rob_ready_k, rob_data_k, v, d, id);
        chk({tag, ".val_k"}, dec_val_k, v);
        chk({tag, ".dep_k"}, 32'(dec_has_dep_k), 32'(d));
        if (d) chk({tag, ".tag_k"}, 32'(dec_dep_k), 32'(id));
        if (mknown[dec_rs2]) chk({tag, ".rob_id_k"}, 32'(rob_id_k), 32'(mtag[dec_rs2]));
    endtask

    task automatic model_update();
        if (rdy_in) begin
            if (flush) begin
                for (int r = 0; r < 32; r++) begin
                    mbusy[r] = 1'b0;
                    if (r != 0) mknown[r] = 1'b0;
                end
            end else begin
                if (commit_reg_id != 5'd0) begin
                    mval[commit_reg_id] = commit_data;
                    if (mbusy[commit_reg_id] && mtag[commit_reg_id] == commit_rob_id)
                        mbusy[commit_reg_id] = 1'b0;
                end
                if (dec_rdy && dec_rd != 5'd0) begin
                    mbusy[dec_rd] = 1'b1; mtag[dec_rd] = dec_rob_id; mknown[dec_rd] = 1'b1;
                end
            end
        end
    endtask

    // Inputs are set just after an edge; check lookups, clock once, update the model.
    task automatic step(input string tag);
        #1;
        check_ops(tag);
        @(posedge clk_in);
        model_update();
        #1;
    endtask

    task automatic idle();
        rdy_in = 1'b1; flush = 1'b0; dec_rdy = 1'b0; dec_rd = '0; dec_rob_id = '0;
        dec_rs1 = '0; dec_rs2 = '0; rob_ready_j = 1'b0; rob_ready_k = 1'b0;
        rob_data_j = '0; rob_data_k = '0; commit_reg_id = '0; commit_data = '0;
        commit_rob_id = '0;
    endtask

    initial begin
        idle();
        rst_in = 1'b1;
        model_reset();
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b0;

        // Reset state
        dec_rs1 = 5'd5; dec_rs2 = 5'd17;
        #1;
        chk("rst_val_j", dec_val_j, 32'd0);
        chk("rst_dep_j", 32'(dec_has_dep_j), 32'd0);
        chk("rst_tag_j", 32'(dec_dep_j), 32'd0);
        chk("rst_robid_j", 32'(rob_id_j), 32'd0);
        step("rst");

        // Rename x3 -> rob 2, then dependency
        idle(); dec_rdy = 1'b1; dec_rd = 5'd3; dec_rob_id = 4'd2; step("ren3");
        idle(); dec_rs1 = 5'd3;
        #1;
        chk("dep3_has", 32'(dec_has_dep_j), 32'd1);
        chk("dep3_tag", 32'(dec_dep_j), 32'd2);
        chk("dep3_robid", 32'(rob_id_j), 32'd2);
        step("dep3");

        // ROB forwarding
        idle(); dec_rs1 = 5'd3; rob_ready_j = 1'b1; rob_data_j = 32'hAB;
        #1;
        chk("robfwd_val", dec_val_j, 32'hAB);
        chk("robfwd_dep", 32'(dec_has_dep_j), 32'd0);
        step("robfwd");

        // Commit forwarding in the commit cycle, then architectural value
        idle(); dec_rs1 = 5'd3; commit_reg_id = 5'd3; commit_rob_id = 4'd2; commit_data = 32'hAB;
        #1;
        chk("cfwd_val", dec_val_j, 32'hAB);
        step("cfwd");
        idle(); dec_rs1 = 5'd3;
        #1;
        chk("post_commit_val", dec_val_j, 32'hAB);
        chk("post_commit_dep", 32'(dec_has_dep_j), 32'd0);
        step("post_commit");

        // Stale commit on x4
        idle(); dec_rdy = 1'b1; dec_rd = 5'd4; dec_rob_id = 4'd1; step("ren4a");
        idle(); dec_rdy = 1'b1; dec_rd = 5'd4; dec_rob_id = 4'd5; step("ren4b");
        idle(); commit_reg_id = 5'd4; commit_rob_id = 4'd1; commit_data = 32'd7; step("stale");
        idle(); dec_rs1 = 5'd4;
        #1;
        chk("stale_has", 32'(dec_has_dep_j), 32'd1);
        chk("stale_tag", 32'(dec_dep_j), 32'd5);
        step("stale_chk");

        // Same-cycle rename and commit on x6
        idle(); dec_rdy = 1'b1; dec_rd = 5'd6; dec_rob_id = 4'd4; step("ren6a");
        idle(); dec_rdy = 1'b1; dec_rd = 5'd6; dec_rob_id = 4'd3;
        commit_reg_id = 5'd6; commit_rob_id = 4'd4; commit_data = 32'd9; step("rc6");
        idle(); dec_rs1 = 5'd6;
        #1;
        chk("rc6_has", 32'(dec_has_dep_j), 32'd1);
        chk("rc6_tag", 32'(dec_dep_j), 32'd3);
        step("rc6_chk");

        // Writes to x0 are ignored
        idle(); dec_rdy = 1'b1; dec_rd = 5'd0; dec_rob_id = 4'd7;
        commit_reg_id = 5'd0; commit_data = 32'hFF; step("x0w");
        idle(); dec_rs1 = 5'd0; dec_rs2 = 5'd0;
        #1;
        chk("x0_val", dec_val_j, 32'd0);
        chk("x0_dep", 32'(dec_has_dep_j), 32'd0);
        step("x0_chk");

        // Flush stimulus with rdy_in low changes nothing, then with rdy_in high
        idle(); dec_rdy = 1'b1; dec_rd = 5'd1; dec_rob_id = 4'd8; step("ren1");
        idle(); dec_rdy = 1'b1; dec_rd = 5'd2; dec_rob_id = 4'd9; step("ren2");
        idle(); rdy_in = 1'b0; flush = 1'b1; commit_reg_id = 5'd1; commit_rob_id = 4'd8;
        commit_data = 32'h55; dec_rdy = 1'b1; dec_rd = 5'd7; dec_rob_id = 4'd10; step("nordy");
        idle(); dec_rs1 = 5'd1; dec_rs2 = 5'd7;
        #1;
        chk("nordy_x1_has", 32'(dec_has_dep_j), 32'd1);
        chk("nordy_x1_tag", 32'(dec_dep_j), 32'd8);
        chk("nordy_x7_has", 32'(dec_has_dep_k), 32'd0);
        step("nordy_chk");
        idle(); flush = 1'b1; commit_reg_id = 5'd1; commit_rob_id = 4'd8;
        commit_data = 32'h55; dec_rdy = 1'b1; dec_rd = 5'd7; dec_rob_id = 4'd10; step("flush");
        idle(); dec_rs1 = 5'd1; dec_rs2 = 5'd7;
        #1;
        chk("fl_x1_has", 32'(dec_has_dep_j), 32'd0);
        chk("fl_x1_val", dec_val_j, 32'd0);
        chk("fl_x7_has", 32'(dec_has_dep_k), 32'd0);
        step("fl_a");
        idle(); dec_rs1 = 5'd4; dec_rs2 = 5'd6;
        #1;
        chk("fl_x4_val", dec_val_j, 32'd7);
        chk("fl_x6_val", dec_val_k, 32'd9);
        step("fl_b");

        // Asynchronous reset without a clock edge
        idle(); dec_rdy = 1'b1; dec_rd = 5'd9; dec_rob_id = 4'd3;
        commit_reg_id = 5'd4; commit_data = 32'h1234; step("pre_arst");
        idle(); dec_rs1 = 5'd9; dec_rs2 = 5'd4;
        rst_in = 1'b1;
        #2;
        chk("arst_dep", 32'(dec_has_dep_j), 32'd0);
        chk("arst_robid", 32'(rob_id_j), 32'd0);
        chk("arst_val", dec_val_k, 32'd0);
        model_reset();
        @(posedge clk_in);
        #1 rst_in = 1'b0;

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            logic [4:0] cr;
            rdy_in        = ($urandom_range(9) != 0);
            flush         = ($urandom_range(24) == 0);
            dec_rs1       = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(7));
            dec_rs2       = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(7));
            dec_rdy       = ($urandom_range(1) == 0);
            dec_rd        = 5'($urandom_range(7));
            dec_rob_id    = 4'($urandom_range(15));
            rob_ready_j   = ($urandom_range(2) == 0);
            rob_ready_k   = ($urandom_range(2) == 0);
            rob_data_j    = $urandom;
            rob_data_k    = $urandom;
            cr            = 5'($urandom_range(7));
            commit_reg_id = cr;
            commit_rob_id = ($urandom_range(2) != 0) ? mtag[cr] : 4'($urandom_range(15));
            commit_data   = $urandom;
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
